// File: rtl/secure_router_p.sv
// secure_router_p: accepts one word per valid/ready handshake, checks the key
// and destination, then serialises the payload LSB-first onto the selected
// channel with a per-channel strobe. Rejected words are dropped and counted.
module secure_router_p #(
   parameter int               DATA_W = 4,
   parameter int               NUM_CH = 4,
   parameter int               KEY_W  = 4,
   parameter logic [KEY_W-1:0] KEY    = 4'hA,
   localparam int              ADDR_W = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [KEY_W-1:0]  in_key,
   input  logic [DATA_W-1:0] in_data,
   output logic [NUM_CH-1:0] data_out,
   output logic [NUM_CH-1:0] strobe_out,
   output logic              err_pulse,
   output logic [7:0]        drop_count
);

   localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t              state_q,  state_d;
   logic [DATA_W-1:0]   shift_q,  shift_d;
   logic [CNT_W-1:0]    cnt_q,    cnt_d;
   logic [NUM_CH-1:0]   strobe_q, strobe_d;
   logic [NUM_CH-1:0]   data_q,   data_d;
   logic                err_q,    err_d;
   logic [7:0]          drop_q,   drop_d;

   logic                accept;
   logic                pass;
   logic [NUM_CH-1:0]   sel_onehot;

   // Ready is the only combinational output; it follows the state directly.
   assign in_ready   = (state_q == IDLE);
   assign accept     = in_valid & in_ready;
   // The address is widened by one bit so NUM_CH itself is representable.
   assign pass       = (in_key == KEY) && ({1'b0, in_addr} < (ADDR_W + 1)'(NUM_CH));
   assign sel_onehot = NUM_CH'(1) << in_addr;

   // Next-state and next-output logic; the strobe register doubles as the latched address.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d  = state_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      strobe_d = strobe_q;
      data_d   = data_q;
      err_d    = 1'b0;
      drop_d   = drop_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (pass) begin
                  state_d  = SHIFT;
                  shift_d  = in_data >> 1;
                  cnt_d    = '0;
                  strobe_d = sel_onehot;
                  data_d   = sel_onehot & {NUM_CH{in_data[0]}};
               end else begin
                  err_d = 1'b1;
                  if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
               end
            end
         end
         SHIFT: begin
            if (cnt_q == LAST_BIT) begin
               state_d  = IDLE;
               shift_d  = '0;
               strobe_d = '0;
               data_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               data_d  = strobe_q & {NUM_CH{shift_q[0]}};
               shift_d = shift_q >> 1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset aborts any frame in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
         strobe_q <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
         drop_q   <= 8'h00;
      end else begin
         // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         strobe_q <= strobe_d;
         data_q   <= data_d;
         err_q    <= err_d;
         drop_q   <= drop_d;
      end
   end

   assign data_out   = data_q;
   assign strobe_out = strobe_q;
   assign err_pulse  = err_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_secure_router_p.sv
// Directed bench for secure_router_p: a default 4-channel instance and a
// 3-channel instance sharing clock and reset.
module tb_secure_router_p;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Default instance (DATA_W=4, NUM_CH=4, KEY=A)
   logic       in_valid, in_ready, err_pulse;
   logic [1:0] in_addr;
   logic [3:0] in_key, in_data, data_out, strobe_out;
   logic [7:0] drop_count;

   // NUM_CH=3 instance
   logic       v3, rdy3, err3;
   logic [1:0] addr3;
   logic [3:0] key3, dat3;
   logic [2:0] dout3, strb3;
   logic [7:0] drop3;

   int errors = 0;
   int checks = 0;

   secure_router_p dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_key(in_key), .in_data(in_data),
      .data_out(data_out), .strobe_out(strobe_out),
      .err_pulse(err_pulse), .drop_count(drop_count)
   );

   secure_router_p #(.NUM_CH(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(rdy3),
      .in_addr(addr3), .in_key(key3), .in_data(dat3),
      .data_out(dout3), .strobe_out(strb3),
      .err_pulse(err3), .drop_count(drop3)
   );

   // Advance one clock; outputs are sampled 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_key = '0; in_data = '0;
      v3 = 1'b0; addr3 = '0; key3 = '0; dat3 = '0;
      #2;
      checks++;
      if ({strobe_out, data_out, err_pulse, drop_count} !== 17'd0) begin
         errors++;
         $display("FAIL reset_outputs: got strb=%b data=%b err=%b drop=%0d expected all 0",
                  strobe_out, data_out, err_pulse, drop_count);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b expected 1", in_ready);
      end
      checks++;
      if ({strb3, dout3, err3, drop3, rdy3} !== 16'd1) begin
         errors++; $display("FAIL reset_ch3: got strb=%b data=%b err=%b drop=%0d rdy=%b expected 0/0/0/0/1",
                             strb3, dout3, err3, drop3, rdy3);
      end
      #10 rst_n = 1'b1;
      step();
   endtask

   // addr=2, data=1110 -> bits 0,1,1,1 on channel 2 for exactly 4 cycles.
   task automatic test_good_frame();
      logic [3:0] pay;
      pay = 4'b1110;
      in_valid = 1'b1; in_addr = 2'd2; in_key = 4'hA; in_data = pay;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (strobe_out !== 4'b0100 || in_ready !== 1'b0) begin
            errors++; $display("FAIL frame_strobe[%0d]: got strb=%b rdy=%b expected 0100/0", i, strobe_out, in_ready);
         end
         checks++;
         if (data_out !== (pay[i] ? 4'b0100 : 4'b0000)) begin
            errors++; $display("FAIL frame_data[%0d]: got %b expected bit %b on ch2", i, data_out, pay[i]);
         end
         step();
      end
      checks++;
      if (strobe_out !== 4'b0000 || data_out !== 4'b0000 || in_ready !== 1'b1) begin
         errors++; $display("FAIL frame_end: got strb=%b data=%b rdy=%b expected 0000/0000/1",
                             strobe_out, data_out, in_ready);
      end
      checks++;
      if (err_pulse !== 1'b0 || drop_count !== 8'd0) begin
         errors++; $display("FAIL frame_noerr: got err=%b drop=%0d expected 0/0", err_pulse, drop_count);
      end
   endtask

   // Wrong key: dropped, one-cycle err_pulse, drop_count=1, never busy.
   task automatic test_bad_key();
      in_valid = 1'b1; in_addr = 2'd1; in_key = 4'h5; in_data = 4'hF;
      step();
      in_valid = 1'b0;
      checks++;
      if (err_pulse !== 1'b1 || drop_count !== 8'd1) begin
         errors++; $display("FAIL badkey_err: got err=%b drop=%0d expected 1/1", err_pulse, drop_count);
      end
      checks++;
      if (strobe_out !== 4'b0000 || data_out !== 4'b0000 || in_ready !== 1'b1) begin
         errors++; $display("FAIL badkey_idle: got strb=%b data=%b rdy=%b expected 0000/0000/1",
                             strobe_out, data_out, in_ready);
      end
      step();
      checks++;
      if (err_pulse !== 1'b0 || drop_count !== 8'd1) begin
         errors++; $display("FAIL badkey_pulse_width: got err=%b drop=%0d expected 0/1", err_pulse, drop_count);
      end
   endtask

   // Two frames with in_valid held high: addr0/0101 then addr3/1011.
   task automatic test_back_to_back();
      logic [3:0] p1, p2;
      int first0, first3;
      p1 = 4'b0101; p2 = 4'b1011;
      first0 = -1; first3 = -1;
      in_valid = 1'b1; in_addr = 2'd0; in_key = 4'hA; in_data = p1;
      step();
      in_addr = 2'd3; in_data = p2;
      for (int k = 0; k < 11; k++) begin
         if (k == 5) in_valid = 1'b0;
         checks++;
         if (!$onehot0(strobe_out)) begin
            errors++; $display("FAIL b2b_onehot[%0d]: got strb=%b expected at most one bit", k, strobe_out);
         end
         if (strobe_out[0] && first0 < 0) first0 = k;
         if (strobe_out[3] && first3 < 0) first3 = k;
         checks++;
         if (k < 4) begin
            if (strobe_out !== 4'b0001 || data_out !== {3'b000, p1[k]}) begin
               errors++; $display("FAIL b2b_f1[%0d]: got strb=%b data=%b expected 0001/%b", k, strobe_out, data_out, {3'b000, p1[k]});
            end
         end else if (k >= 5 && k < 9) begin
            if (strobe_out !== 4'b1000 || data_out !== {p2[k-5], 3'b000}) begin
               errors++; $display("FAIL b2b_f2[%0d]: got strb=%b data=%b expected 1000/%b", k, strobe_out, data_out, {p2[k-5], 3'b000});
            end
         end else begin
            if (strobe_out !== 4'b0000 || data_out !== 4'b0000 || in_ready !== 1'b1) begin
               errors++; $display("FAIL b2b_gap[%0d]: got strb=%b data=%b rdy=%b expected 0000/0000/1", k, strobe_out, data_out, in_ready);
            end
         end
         step();
      end
      checks++;
      if (first0 != 0 || first3 != 5) begin
         errors++; $display("FAIL b2b_spacing: got first0=%0d first3=%0d expected 0/5", first0, first3);
      end
   endtask

   // Reset during bit 2 clears outputs asynchronously; next frame routes cleanly.
   task automatic test_reset_midframe();
      logic [3:0] pay;
      pay = 4'b0110;
      in_valid = 1'b1; in_addr = 2'd1; in_key = 4'hA; in_data = 4'b1111;
      step();
      in_valid = 1'b0;
      step();
      step();
      checks++;
      if (strobe_out !== 4'b0010 || data_out !== 4'b0010) begin
         errors++; $display("FAIL rstmid_pre: got strb=%b data=%b expected 0010/0010", strobe_out, data_out);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (strobe_out !== 4'b0000 || data_out !== 4'b0000 || in_ready !== 1'b1 || drop_count !== 8'd0) begin
         errors++; $display("FAIL rstmid_async: got strb=%b data=%b rdy=%b drop=%0d expected 0000/0000/1/0",
                             strobe_out, data_out, in_ready, drop_count);
      end
      #3 rst_n = 1'b1;
      step();
      checks++;
      if (strobe_out !== 4'b0000 || in_ready !== 1'b1) begin
         errors++; $display("FAIL rstmid_noresume: got strb=%b rdy=%b expected 0000/1", strobe_out, in_ready);
      end
      in_valid = 1'b1; in_addr = 2'd3; in_key = 4'hA; in_data = pay;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (strobe_out !== 4'b1000 || data_out !== {pay[i], 3'b000}) begin
            errors++; $display("FAIL rstmid_frame[%0d]: got strb=%b data=%b expected 1000/%b", i, strobe_out, data_out, {pay[i], 3'b000});
         end
         step();
      end
   endtask

   // NUM_CH=3: addr 3 is out of range; channel 2 works; drop_count saturates.
   task automatic test_num_ch3();
      logic [3:0] pay;
      int exp_drop;
      pay = 4'b1001;
      v3 = 1'b1; addr3 = 2'd3; key3 = 4'hA; dat3 = 4'hF;
      step();
      v3 = 1'b0;
      checks++;
      if (err3 !== 1'b1 || drop3 !== 8'd1 || strb3 !== 3'b000 || rdy3 !== 1'b1) begin
         errors++; $display("FAIL ch3_badaddr: got err=%b drop=%0d strb=%b rdy=%b expected 1/1/000/1", err3, drop3, strb3, rdy3);
      end
      v3 = 1'b1; addr3 = 2'd2; key3 = 4'hA; dat3 = pay;
      step();
      v3 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (strb3 !== 3'b100 || dout3 !== {pay[i], 2'b00} || err3 !== 1'b0) begin
            errors++; $display("FAIL ch3_frame[%0d]: got strb=%b data=%b err=%b expected 100/%b/0", i, strb3, dout3, err3, {pay[i], 2'b00});
         end
         step();
      end
      exp_drop = 1;
      v3 = 1'b1; addr3 = 2'd0; key3 = 4'h5; dat3 = 4'h3;
      for (int n = 0; n < 300; n++) begin
         step();
         exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
         checks++;
         if (drop3 !== 8'(exp_drop) || err3 !== 1'b1) begin
            errors++; $display("FAIL ch3_sat[%0d]: got drop=%0d err=%b expected %0d/1", n, drop3, err3, exp_drop);
         end
      end
      v3 = 1'b0;
      step();
      checks++;
      if (drop3 !== 8'hFF || err3 !== 1'b0) begin
         errors++; $display("FAIL ch3_final: got drop=%0d err=%b expected 255/0", drop3, err3);
      end
      checks++;
      if (drop_count !== 8'd0 || strobe_out !== 4'b0000) begin
         errors++; $display("FAIL ch4_untouched: got drop=%0d strb=%b expected 0/0000", drop_count, strobe_out);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_key();
      test_back_to_back();
      test_reset_midframe();
      test_num_ch3();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
